// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
// The ack watchdog is compiled in with MEM_ARB_TIMEOUT_EN.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DATA  = 2'd1,
      FETCH = 2'd2,
      DONE  = 2'd3
   } arbState_t;

   localparam logic [3:0] BE_WORD = 4'hF;
   localparam int TIMEOUT_DEF = 255;

   function automatic int toCntW(input int cycles);
      return $clog2(cycles + 1);
   endfunction

   localparam int TO_CNT_W = toCntW(TIMEOUT_DEF);

endpackage

// File: rtl/mem_arb_timeout.sv
// Ack watchdog: counts wait cycles of an outstanding memory request.
// Only instantiated when MEM_ARB_TIMEOUT_EN is defined.
module mem_arb_timeout
   import mem_arb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   output logic expired
);

   localparam int CW = toCntW(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (!run) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Fires during the last allowed wait cycle so done lands after it.
   assign expired = run & (cnt == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between fetch and memory stages.
// Optional ack watchdog and bus_err under MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pipe_hold,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [31:0]       if_rdata,
   output logic              if_done,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [3:0]        dm_be,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [31:0]       dm_wdata,
   output logic [31:0]       dm_rdata,
   output logic              dm_done,
   output logic              mem_req,
   output logic              mem_we,
   output logic [3:0]        mem_be,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ack,
   output logic              stall_f,
   output logic              stall_m,
   output logic              bus_err
);

   arbState_t state;
   logic advance;
   logic hit;
   logic [31:0] rdataIn;

   assign stall_f = if_req & ~if_done;
   assign stall_m = dm_req & ~dm_done;
   assign advance = ~pipe_hold & ~stall_f & ~stall_m;

`ifdef MEM_ARB_TIMEOUT_EN
   logic expired;

   mem_arb_timeout #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) uTimeout (
      .clk    (clk),
      .reset  (reset),
      .run    (mem_req),
      .expired(expired)
   );

   assign hit     = mem_req & (mem_ack | expired);
   assign rdataIn = mem_ack ? mem_rdata : 32'h0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus_err <= 1'b0;
      end else if (mem_req & expired & ~mem_ack) begin
         bus_err <= 1'b1;
      end
   end
`else
   assign hit     = mem_req & mem_ack;
   assign rdataIn = mem_rdata;
   // Watchdog depth is meaningless here; reference keeps it tied off.
   assign bus_err = (TIMEOUT_CYCLES < 0);
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_be    <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_rdata  <= '0;
         if_done   <= 1'b0;
         dm_rdata  <= '0;
         dm_done   <= 1'b0;
      end else begin
         if (advance) begin
            if_done <= 1'b0;
            dm_done <= 1'b0;
         end
         unique case (state)
            IDLE: begin
               if (dm_req & ~dm_done) begin
                  state     <= DATA;
                  mem_req   <= 1'b1;
                  mem_we    <= dm_we;
                  mem_be    <= dm_be;
                  mem_addr  <= dm_addr;
                  mem_wdata <= dm_wdata;
               end else if (if_req & ~if_done) begin
                  state     <= FETCH;
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b0;
                  mem_be    <= BE_WORD;
                  mem_addr  <= if_addr;
                  mem_wdata <= '0;
               end
            end
            DATA: begin
               if (hit) begin
                  state    <= DONE;
                  mem_req  <= 1'b0;
                  dm_rdata <= rdataIn;
                  dm_done  <= 1'b1;
               end
            end
            FETCH: begin
               if (hit) begin
                  state    <= DONE;
                  mem_req  <= 1'b0;
                  if_rdata <= rdataIn;
                  if_done  <= 1'b1;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported instruction/data memory between the pipeline's fetch stage (PCF/InstrF) and memory stage (ALUResultM/WriteDataM/MemDataM). Requests are served one at a time over a req/ack memory handshake. The block holds each completed result until the pipeline advances. It generates the fetch and memory stall terms the hazard unit merges into StallF/StallD/FlushE.

## Interface
- ADDR_W, 32, memory address width
- TIMEOUT_CYCLES, 255, ack wait limit (used only with timeout compiled in)
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- pipe_hold  in  1  other hazard stall (load-use etc.); pipeline frozen
- if_req  in  1  fetch wants instruction at if_addr
- if_addr  in  ADDR_W  fetch address (PCF)
- if_rdata  out  32  instruction (InstrF), registered
- if_done  out  1  if_rdata valid, held until advance
- dm_req  in  1  memory-stage access wanted
- dm_we  in  1  store
- dm_be  in  4  byte enables
- dm_addr  in  ADDR_W  data address (ALUResultM)
- dm_wdata  in  32  store data (WriteDataM)
- dm_rdata  out  32  load data (MemDataM), registered
- dm_done  out  1  dm_rdata valid / store complete, held until advance
- mem_req, mem_we, mem_be, mem_addr, mem_wdata  out  1/1/4/ADDR_W/32  memory request, registered
- mem_rdata  in  32  memory read data, valid when mem_ack=1
- mem_ack  in  1  memory completes current request
- stall_f  out  1  if_req & ~if_done
- stall_m  out  1  dm_req & ~dm_done
- bus_err  out  1  sticky timeout error

## Operation
- Internal advance = ~pipe_hold & ~stall_f & ~stall_m. At an advancing edge, if_done and dm_done clear.
- FSM states: IDLE, DATA, FETCH, DONE.
- IDLE: if dm_req & ~dm_done, go to DATA; else if if_req & ~if_done, go to FETCH; else stay. Data wins ties because it belongs to the older instruction.
- Entering DATA/FETCH latches the address, we, be and wdata into the mem_* registers and raises mem_req. Fetch uses mem_we=0 and mem_be=4'hF.
- DATA/FETCH: mem_req and payload stay stable until mem_ack=1. On ack: mem_rdata goes to dm_rdata or if_rdata, the matching done flag sets, mem_req drops, and the FSM goes to DONE.
- DONE: one-cycle turnaround. Requests are not sampled here because the done flag is still rising. Next state is IDLE.
- A requester with done=1 is never reissued. No request is ever preempted.
- Stores: dm_rdata is loaded from mem_rdata anyway; the pipeline ignores it.

## Timing
- Reset: state IDLE; all outputs 0, including mem_req, if_done, dm_done, if_rdata, dm_rdata and bus_err.
- Request seen in IDLE at edge k gives mem_req=1 in cycle k+1.
- Ack in cycle k+a (a≥1) gives done=1 from edge k+a+1.
- Minimum latency is 2 cycles from the sampled request to done.
- mem_req is low for at least 2 cycles (DONE, then IDLE) between transactions.
- stall_f/stall_m are combinational from registered done flags and requester inputs, with no path from mem_ack.
- Both requesters pending: the data transaction completes first; the fetch issues from the next IDLE. The pipeline stays frozen until both done flags are set.
- reset asserted mid-transaction: mem_req drops immediately and the result is discarded. The memory model must tolerate an abandoned request.
- mem_ack while mem_req=0 is ignored.

## Configuration
- MEM_ARB_TIMEOUT_EN defined:
  - A counter runs while in DATA/FETCH and clears on state exit.
  - When it reaches TIMEOUT_CYCLES with no ack, the FSM forces the ack path: rdata is set to 0, done is set, bus_err sets and stays set until reset.
- MEM_ARB_TIMEOUT_EN undefined: the FSM waits for ack forever; bus_err is tied to 0 and the counter is absent.

## Structure
- Shared package mem_arb_pkg holds:
  - the FSM state enum (IDLE, DATA, FETCH, DONE);
  - the constant BE_WORD = 4'hF;
  - the timeout counter width, $clog2(TIMEOUT_CYCLES+1).
- Optional sub-module mem_arb_timeout: counter plus expiry compare, instantiated only under MEM_ARB_TIMEOUT_EN.

## Test plan
- Fetch only, ack 1 cycle after mem_req, if_addr=0x100, mem_rdata=0x00500093: mem_addr=0x100, mem_we=0, if_rdata=0x00500093 and if_done=1 two cycles after IDLE sample. stall_f is 1 until then; if_done clears on the next advance.
- dm_req (load 0x200) and if_req (0x104) in the same IDLE cycle: the data transaction issues first with dm_rdata = mem_rdata. The fetch issues after DONE+IDLE. stall_m drops before stall_f, and no advance occurs until both are low.
- Store with dm_be=4'b0011, dm_wdata=0xAABBCCDD, ack delayed 5 cycles: mem_we=1 and mem_be=0011 with payload stable across all 5 wait cycles; dm_done follows the ack edge.
- pipe_hold=1 for 3 cycles after both done flags are set: no reissue (mem_req stays 0) and the flags stay held. Both clear on the first edge with pipe_hold=0.
- reset pulled low during FETCH wait: mem_req=0 asynchronously and all outputs return to 0. After reset releases, the fetch reissues from IDLE.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, ack never arrives: after 8 wait cycles if_done=1, if_rdata=0, and bus_err=1 and stays set. Without the macro, mem_req stays high indefinitely.
